// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: arbiter FSM state type and default bus widths
package bus_arb_pkg;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;
  typedef enum logic [2:0] {IDLE, SNOOP, WRITEBACK, ACCESS, RESP} arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot grant to the first requester strictly after ptr_i, cyclically
module rr_arbiter #(
  parameter int NUM_CORES = 4
) (
  input  logic [NUM_CORES-1:0]         req_i,
  input  logic [$clog2(NUM_CORES)-1:0] ptr_i,
  output logic [NUM_CORES-1:0]         grant_o
);
  localparam int IW = $clog2(NUM_CORES);
  logic [IW-1:0] idx;
  logic found;
  // walk the cores starting just after the pointer and take the first requester
  always_comb begin
    grant_o = '0;
    found = 1'b0;
    idx = '0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      idx = IW'((int'(ptr_i) + k) % NUM_CORES);
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/multicore_bus_arbiter.sv
// multicore_bus_arbiter: round-robin shared-memory arbiter with snoop/writeback, snoop path enabled by MULTICORE_ARB_SNOOP_EN
module multicore_bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CORES-1:0]        req_valid,
  input  logic [NUM_CORES-1:0]        req_we,
  input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
  input  logic [NUM_CORES*DATA_W-1:0] req_wdata,
  output logic [NUM_CORES-1:0]        grant,
  output logic [NUM_CORES-1:0]        resp_valid,
  output logic [DATA_W-1:0]           resp_rdata,
  output logic                        resp_shared,
  output logic                        snoop_valid,
  output logic [ADDR_W-1:0]           snoop_addr,
  output logic                        snoop_wr_intent,
  input  logic [NUM_CORES-1:0]        snoop_hit,
  input  logic [NUM_CORES-1:0]        snoop_dirty,
  input  logic [NUM_CORES*DATA_W-1:0] snoop_wbdata,
  output logic                        mem_rd,
  output logic                        mem_wr,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  input  logic                        mem_ready
);
`ifdef MULTICORE_ARB_SNOOP_EN
  localparam bit SNOOP_EN = 1'b1;
`else
  localparam bit SNOOP_EN = 1'b0;
`endif
  localparam int IW = $clog2(NUM_CORES);
  arb_state_t state_q, state_d;
  logic [NUM_CORES-1:0] grant_q, grant_d, next_grant, hit_m, dirty_m;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic we_q, we_d, shared_q, shared_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, wb_q, wb_d, rdata_q, rdata_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d, gidx;
  rr_arbiter #(.NUM_CORES(NUM_CORES)) u_rr (
    .req_i  (req_valid),
    .ptr_i  (rr_ptr_q),
    .grant_o(next_grant)
  );
  assign hit_m   = snoop_hit & ~grant_q;
  assign dirty_m = snoop_dirty & ~grant_q;
  // index of the current owner, loaded into the round-robin pointer on completion
  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_CORES; i++) if (grant_q[i]) gidx = IW'(i);
  end
  // transaction sequencing and capture of request, snoop and memory data
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    shared_d = shared_q;
    wb_d     = wb_q;
    rdata_d  = rdata_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: if (|req_valid) begin
        grant_d = next_grant;
        for (int i = 0; i < NUM_CORES; i++) if (next_grant[i]) begin
          addr_d  = req_addr[i*ADDR_W +: ADDR_W];
          we_d    = req_we[i];
          wdata_d = req_wdata[i*DATA_W +: DATA_W];
        end
        shared_d = 1'b0;
        rdata_d  = '0;
        state_d  = SNOOP_EN ? SNOOP : ACCESS;
      end
      SNOOP: begin
        shared_d = |hit_m;
        for (int i = NUM_CORES - 1; i >= 0; i--) if (dirty_m[i]) wb_d = snoop_wbdata[i*DATA_W +: DATA_W];
        state_d = |dirty_m ? WRITEBACK : ACCESS;
      end
      WRITEBACK: if (mem_ready) state_d = ACCESS;
      ACCESS: if (mem_ready) begin
        rdata_d = we_q ? '0 : mem_rdata;
        state_d = RESP;
      end
      RESP: begin
        grant_d  = '0;
        rr_ptr_d = gidx;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers; reset aborts any transaction and hands core 0 first priority
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      shared_q <= 1'b0;
      wb_q     <= '0;
      rdata_q  <= '0;
      rr_ptr_q <= IW'(NUM_CORES - 1);
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      shared_q <= shared_d;
      wb_q     <= wb_d;
      rdata_q  <= rdata_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end
  assign grant           = grant_q;
  assign resp_valid      = state_q == RESP ? grant_q : '0;
  assign resp_rdata      = state_q == RESP ? rdata_q : '0;
  assign resp_shared     = SNOOP_EN && state_q == RESP && shared_q;
  assign snoop_valid     = SNOOP_EN && state_q == SNOOP;
  assign snoop_addr      = snoop_valid ? addr_q : '0;
  assign snoop_wr_intent = snoop_valid && we_q;
  assign mem_wr          = state_q == WRITEBACK || (state_q == ACCESS && we_q);
  assign mem_rd          = state_q == ACCESS && !we_q;
  assign mem_addr        = (state_q == WRITEBACK || state_q == ACCESS) ? addr_q : '0;
  assign mem_wdata       = state_q == WRITEBACK ? wb_q : mem_wr ? wdata_q : '0;
endmodule

// File: tb/tb_multicore_bus_arbiter.sv
// tb_multicore_bus_arbiter: directed and random transactions against a transaction-level reference model
module tb_multicore_bus_arbiter;
  localparam int NC = 4, AW = 5, DW = 32;
`ifdef MULTICORE_ARB_SNOOP_EN
  localparam bit SN = 1'b1;
`else
  localparam bit SN = 1'b0;
`endif
  logic clk = 1'b0, reset;
  logic [NC-1:0] req_valid, req_we, grant, resp_valid, snoop_hit, snoop_dirty;
  logic [NC*AW-1:0] req_addr;
  logic [NC*DW-1:0] req_wdata, snoop_wbdata;
  logic [DW-1:0] resp_rdata, mem_wdata, mem_rdata;
  logic resp_shared, snoop_valid, snoop_wr_intent, mem_rd, mem_wr, mem_ready;
  logic [AW-1:0] snoop_addr, mem_addr;
  logic [DW-1:0] mem [32];
  logic [DW-1:0] ref_mem [32];
  int wait_n = 0, ws_cnt = 0, last = NC - 1, checks = 0, errors = 0;
  always #5 clk = ~clk;
  multicore_bus_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .grant(grant), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_shared(resp_shared), .snoop_valid(snoop_valid), .snoop_addr(snoop_addr),
    .snoop_wr_intent(snoop_wr_intent), .snoop_hit(snoop_hit), .snoop_dirty(snoop_dirty),
    .snoop_wbdata(snoop_wbdata), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );
  assign mem_ready = ws_cnt >= wait_n;
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    ws_cnt <= ((mem_rd || mem_wr) && !mem_ready) ? ws_cnt + 1 : 0;
    if (mem_wr && mem_ready) mem[mem_addr] <= mem_wdata;
  end
  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic post(input int c, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[c] = 1'b1;
    req_we[c] = we;
    req_addr[c*AW +: AW] = a;
    req_wdata[c*DW +: DW] = d;
  endtask
  task automatic serve(input bit keep);
    int own, dirty, n, rdc, wrc, both, snc, lat, idx;
    logic [AW-1:0] a, sa;
    logic [DW-1:0] exp_rd;
    logic sw;
    own = -1; dirty = -1; n = 0; rdc = 0; wrc = 0; both = 0; snc = 0; sw = 1'b0; sa = '0;
    for (int k = 1; k <= NC; k++) begin
      idx = (last + k) % NC;
      if (own < 0 && req_valid[idx]) own = idx;
    end
    if (own < 0) return;
    a = req_addr[own*AW +: AW];
    if (SN) for (int j = NC - 1; j >= 0; j--) if (j != own && snoop_dirty[j]) dirty = j;
    if (dirty >= 0) ref_mem[a] = snoop_wbdata[dirty*DW +: DW];
    exp_rd = req_we[own] ? '0 : ref_mem[a];
    if (req_we[own]) ref_mem[a] = req_wdata[own*DW +: DW];
    lat = (SN ? 3 : 2) + wait_n + (dirty >= 0 ? 1 + wait_n : 0);
    while (resp_valid == '0 && n < 60) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      rdc += int'(mem_rd);
      wrc += int'(mem_wr);
      both += int'(mem_rd && mem_wr);
      if (snoop_valid) begin
        snc++;
        sw = snoop_wr_intent;
        sa = snoop_addr;
      end
    end
    check("latency", n, lat);
    check("resp_valid", 32'(resp_valid), 32'(1) << own);
    check("grant", 32'(grant), 32'(1) << own);
    check("resp_rdata", resp_rdata, exp_rd);
    check("resp_shared", 32'(resp_shared), 32'(SN && |(snoop_hit & ~(NC'(1) << own))));
    check("snoop_count", snc, 32'(SN));
    check("snoop_wr_intent", 32'(sw), 32'(SN && req_we[own]));
    check("snoop_addr", 32'(sa), SN ? 32'(a) : 32'(0));
    check("rd_cycles", rdc, req_we[own] ? 0 : 1 + wait_n);
    check("wr_cycles", wrc, (req_we[own] ? 1 + wait_n : 0) + (dirty >= 0 ? 1 + wait_n : 0));
    check("strobe_overlap", both, 0);
    check("mem_word", mem[a], ref_mem[a]);
    last = own;
    if (!keep) req_valid[own] = 1'b0;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    reset = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    snoop_hit = '0; snoop_dirty = '0; snoop_wbdata = '0;
    for (int i = 0; i < 32; i++) begin
      ref_mem[i] = $urandom;
      mem[i] <= ref_mem[i];
    end
    ref_mem[5] = 32'hDEADBEEF;
    mem[5] <= 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_grant", 32'(grant), 0);
    check("rst_resp_valid", 32'(resp_valid), 0);
    check("rst_mem_strobes", 32'({mem_rd, mem_wr}), 0);
    check("rst_snoop_valid", 32'(snoop_valid), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    post(0, 1'b0, 5'd5, '0);
    serve(1'b0);
    post(1, 1'b0, 5'd7, '0);
    snoop_hit = 4'b0100;
    snoop_dirty = 4'b0100;
    snoop_wbdata[2*DW +: DW] = 32'h12345678;
    serve(1'b0);
    snoop_hit = '0;
    snoop_dirty = '0;
    post(3, 1'b1, 5'd2, 32'hA5A5A5A5);
    serve(1'b0);
    wait_n = 3;
    post(0, 1'b0, 5'd9, '0);
    serve(1'b0);
    wait_n = 0;
    for (int c = 0; c < NC; c++) post(c, 1'b0, AW'(c + 10), '0);
    repeat (8) serve(1'b1);
    req_valid = '0;
    wait_n = 5;
    post(2, 1'b0, 5'd12, '0);
    snoop_hit = 4'b0001;
    snoop_dirty = 4'b0001;
    snoop_wbdata[0 +: DW] = $urandom;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("busy_before_reset", 32'(mem_rd || mem_wr), 1);
    #1 reset = 1'b1;
    #1;
    check("abort_mem_wr", 32'(mem_wr), 0);
    check("abort_mem_rd", 32'(mem_rd), 0);
    check("abort_grant", 32'(grant), 0);
    check("abort_resp_valid", 32'(resp_valid), 0);
    req_valid = '0; snoop_hit = '0; snoop_dirty = '0; wait_n = 0; last = NC - 1;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    post(1, 1'b0, 5'd3, '0);
    post(0, 1'b1, 5'd4, $urandom);
    serve(1'b0);
    serve(1'b0);
    for (int t = 0; t < 40; t++) begin
      for (int c = 0; c < NC; c++)
        if (!req_valid[c] && $urandom_range(0, 1) == 1)
          post(c, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom);
      if (req_valid == '0) post(int'($urandom_range(0, NC - 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom);
      snoop_hit = NC'($urandom);
      snoop_dirty = $urandom_range(0, 2) == 0 ? NC'($urandom) : '0;
      for (int c = 0; c < NC; c++) snoop_wbdata[c*DW +: DW] = $urandom;
      wait_n = int'($urandom_range(0, 2));
      serve(1'b0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicore_bus_arbiter.md
# multicore_bus_arbiter

Parametrised shared-memory bus arbiter and snoop controller for an N-core processor. It replaces the hard-wired two-core memory/hazard wiring with a round-robin grant over `NUM_CORES` request channels. Each granted transaction broadcasts a snoop so that peer caches can report shared/dirty state. A peer holding a dirty line is written back before the main-memory access. It sits between the per-core cache controllers and the single main memory.

## Interface
- `NUM_CORES`, 4: number of request channels, ≥2.
- `ADDR_W`, 5: memory word address width.
- `DATA_W`, 32: data width.

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_CORES  per-core request; held high until `resp_valid` for that core.
- `req_we`  in  NUM_CORES  1 = write (write intent), 0 = read (read intent).
- `req_addr`  in  NUM_CORES*ADDR_W  packed per-core address; core i at [i*ADDR_W +: ADDR_W].
- `req_wdata`  in  NUM_CORES*DATA_W  packed per-core write data.
- `grant`  out  NUM_CORES  one-hot owner of the current transaction; 0 in IDLE.
- `resp_valid`  out  NUM_CORES  one-hot, one-cycle completion pulse.
- `resp_rdata`  out  DATA_W  read data; valid while `resp_valid` is non-zero.
- `resp_shared`  out  1  at least one peer hit during the snoop; valid with `resp_valid`.
- `snoop_valid`  out  1  snoop broadcast, one cycle per transaction.
- `snoop_addr`  out  ADDR_W  snooped address.
- `snoop_wr_intent`  out  1  peers must invalidate on hit.
- `snoop_hit`  in  NUM_CORES  per-core hit response, sampled in SNOOP.
- `snoop_dirty`  in  NUM_CORES  per-core modified-line response, sampled in SNOOP.
- `snoop_wbdata`  in  NUM_CORES*DATA_W  dirty line data, sampled in SNOOP.
- `mem_rd`  out  1  main-memory read strobe.
- `mem_wr`  out  1  main-memory write strobe.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data; valid with `mem_ready`.
- `mem_ready`  in  1  memory access complete; may be high in the first strobe cycle.

## Operation
- FSM states: IDLE, SNOOP, WRITEBACK, ACCESS, RESP.
- **IDLE**
  - If any `req_valid` is high: pick the first requester strictly after `rr_ptr`, cyclically.
  - Register `grant`, the request's address, write-enable and write data.
  - Go to SNOOP.
- **SNOOP** (one cycle)
  - `snoop_valid`=1, `snoop_addr` = request address, `snoop_wr_intent` = request `req_we`.
  - Hit and dirty are masked by `~grant`, so the requester's own response is ignored.
  - `shared_q` = OR of masked hits.
  - If any masked dirty bit is set: latch the lowest-index dirty core's `snoop_wbdata` and go to WRITEBACK. Otherwise go to ACCESS.
  - More than one dirty peer is illegal; the lowest index wins.
- **WRITEBACK**
  - `mem_wr`=1, `mem_addr` = request address, `mem_wdata` = latched writeback data.
  - Hold until `mem_ready`, then go to ACCESS.
- **ACCESS**
  - Assert `mem_wr` (with `req_wdata`) or `mem_rd` (per `req_we`), holding until `mem_ready`.
  - On `mem_ready` with a read: capture `mem_rdata`.
  - Go to RESP.
- **RESP**
  - `resp_valid` = `grant`, `resp_rdata` = captured data (0 for writes), `resp_shared` = `shared_q`.
  - `rr_ptr` ← granted index. Go to IDLE.
- A requester dropping `req_valid` mid-transaction is a protocol violation; the transaction still completes and the pulse still fires.
- At most one of `mem_rd`/`mem_wr` is high in any cycle.

## Timing
- Reset values:
  - State = IDLE; `rr_ptr` = NUM_CORES-1, so core 0 has first priority.
  - `grant`, `resp_valid`, `resp_shared`, `snoop_*`, `mem_rd`, `mem_wr` = 0.
  - `mem_addr`, `mem_wdata`, `resp_rdata` = 0.
- All outputs are registered or decoded from registered state. No combinational path from `req_*` to outputs.
- Latency with `mem_ready` tied high, request seen in IDLE at edge t:
  - SNOOP in cycle t+1, ACCESS in t+2, `resp_valid` in t+3.
  - With a writeback: `resp_valid` in t+4.
- Each memory wait state adds one cycle to WRITEBACK or ACCESS.
- The earliest re-grant is the cycle after RESP. The same core is never granted twice in a row while another core is requesting.
- Reset asserted in any state aborts immediately; no memory strobe survives the reset edge.

## Configuration
- `MULTICORE_ARB_SNOOP_EN` defined:
  - SNOOP and WRITEBACK states are present, with behaviour as above.
- Undefined:
  - IDLE goes directly to ACCESS, so minimum latency is 2 cycles.
  - `snoop_valid`, `snoop_addr` and `snoop_wr_intent` are tied to 0, and `resp_shared` is tied to 0.
  - `snoop_hit`, `snoop_dirty` and `snoop_wbdata` are ignored.

## Structure
- Package `bus_arb_pkg`: state enum `arb_state_t` (IDLE, SNOOP, WRITEBACK, ACCESS, RESP) and default `ADDR_W`/`DATA_W` constants.
- Sub-module `rr_arbiter`: parametrised on `NUM_CORES`; inputs are the request vector and `rr_ptr`, output is the one-hot next grant. Purely combinational.

## Test plan
- **Reset, then single request:** reset, then core 0 reads addr 5 with memory word 5 = 0xDEADBEEF and `mem_ready` tied 1 → `resp_valid`=0001 exactly 3 cycles after the request, `resp_rdata`=0xDEADBEEF, `resp_shared`=0.
- **Fairness:** all 4 cores request continuously → grants in order 0,1,2,3,0, each once per 4 transactions.
- **Dirty peer on read:** core 1 reads addr 7 while core 2 asserts `snoop_hit`, `snoop_dirty` and `snoop_wbdata`=0x12345678 → memory write of 0x12345678 to addr 7, then read; `resp_rdata`=0x12345678, `resp_shared`=1.
- **Write intent:** core 3 writes 0xA5A5A5A5 to addr 2 → `snoop_wr_intent`=1 for one cycle; memory word 2 = 0xA5A5A5A5; `resp_rdata`=0.
- **Memory wait states:** `mem_ready` held low for 3 cycles in ACCESS → `mem_rd` stays high for 4 cycles and `resp_valid` is delayed by 3 cycles.
- **Reset mid-operation:** `reset` pulsed during WRITEBACK → `mem_wr`, `grant` and `resp_valid` go to 0 immediately; the next request is served with core 0 first.
